// File: rtl/bram_tdp_rr_arbiter.sv
// Round-robin arbiter sharing one true-dual-port BRAM among NREQ requesters.
// Grants up to two requests per cycle (one per RAM port) and routes read data back.
module bram_tdp_rr_arbiter #(
   parameter int NREQ   = 4,
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 36
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          we,
   input  logic [NREQ*AWIDTH-1:0]   addr,
   input  logic [NREQ*DWIDTH-1:0]   wdata,
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rvalid,
   output logic [NREQ*DWIDTH-1:0]   rdata,
   output logic                     rce_a,
   output logic                     wce_a,
   output logic [AWIDTH-1:0]        ra_a,
   output logic [AWIDTH-1:0]        wa_a,
   output logic [DWIDTH-1:0]        wd_a,
   input  logic [DWIDTH-1:0]        rq_a,
   output logic                     rce_b,
   output logic                     wce_b,
   output logic [AWIDTH-1:0]        ra_b,
   output logic [AWIDTH-1:0]        wa_b,
   output logic [DWIDTH-1:0]        wd_b,
   input  logic [DWIDTH-1:0]        rq_b
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_sel_a, r_sel_b;
   logic          r_pend_a, r_pend_b;

   logic          w_fa, w_fb;
   logic [IW-1:0] w_ia, w_ib;
   logic [IW:0]   w_sum;
   logic [IW-1:0] w_idx;
   logic          w_coll;

   function automatic logic [IW-1:0] f_next(input logic [IW-1:0] idx);
      return (idx == IW'(NREQ-1)) ? '0 : idx + 1'b1;
   endfunction

   // Cyclic scan from r_ptr: first request takes port A, the next
   // non-colliding one takes port B. Reset masks every grant.
   always_comb begin
      w_fa   = 1'b0;
      w_fb   = 1'b0;
      w_ia   = '0;
      w_ib   = '0;
      w_sum  = '0;
      w_idx  = '0;
      w_coll = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
         w_idx  = w_sum[IW-1:0];
         w_coll = (addr[w_idx*AWIDTH +: AWIDTH] == addr[w_ia*AWIDTH +: AWIDTH]) &&
                  (we[w_idx] || we[w_ia]);
         if (req[w_idx] && !rst) begin
            if (!w_fa) begin
               w_fa = 1'b1;
               w_ia = w_idx;
            end else if (!w_fb && !w_coll) begin
               w_fb = 1'b1;
               w_ib = w_idx;
            end
         end
      end
   end

   always_comb begin
      gnt   = '0;
      rce_a = 1'b0;
      wce_a = 1'b0;
      ra_a  = '0;
      wa_a  = '0;
      wd_a  = '0;
      rce_b = 1'b0;
      wce_b = 1'b0;
      ra_b  = '0;
      wa_b  = '0;
      wd_b  = '0;
      if (w_fa) begin
         gnt[w_ia] = 1'b1;
         if (we[w_ia]) begin
            wce_a = 1'b1;
            wa_a  = addr[w_ia*AWIDTH +: AWIDTH];
            wd_a  = wdata[w_ia*DWIDTH +: DWIDTH];
         end else begin
            rce_a = 1'b1;
            ra_a  = addr[w_ia*AWIDTH +: AWIDTH];
         end
      end
      if (w_fb) begin
         gnt[w_ib] = 1'b1;
         if (we[w_ib]) begin
            wce_b = 1'b1;
            wa_b  = addr[w_ib*AWIDTH +: AWIDTH];
            wd_b  = wdata[w_ib*DWIDTH +: DWIDTH];
         end else begin
            rce_b = 1'b1;
            ra_b  = addr[w_ib*AWIDTH +: AWIDTH];
         end
      end
   end

   // Port B is always later in scan order, so it owns the pointer when used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= '0;
         r_sel_a  <= '0;
         r_sel_b  <= '0;
         r_pend_a <= 1'b0;
         r_pend_b <= 1'b0;
      end else begin
         r_pend_a <= w_fa && !we[w_ia];
         r_pend_b <= w_fb && !we[w_ib];
         r_sel_a  <= w_ia;
         r_sel_b  <= w_ib;
         if (w_fb)      r_ptr <= f_next(w_ib);
         else if (w_fa) r_ptr <= f_next(w_ia);
      end
   end

   always_comb begin
      rvalid = '0;
      rdata  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_pend_a && (r_sel_a == IW'(i))) begin
            rvalid[i]                 = 1'b1;
            rdata[i*DWIDTH +: DWIDTH] = rq_a;
         end else if (r_pend_b && (r_sel_b == IW'(i))) begin
            rvalid[i]                 = 1'b1;
            rdata[i*DWIDTH +: DWIDTH] = rq_b;
         end
      end
   end

endmodule
